// File: rtl/dvi_timing_gen.sv
// Free-running raster position counters with a delayed sync/DE/marker group.
// The delay lines the sync group up with the pixel generator's colour output.
module dvi_timing_gen #(
    parameter int   SCREEN_H_RES = 640,
    parameter int   SCREEN_V_RES = 480,
    parameter int   HSYNC_START  = 656,
    parameter int   HSYNC_END    = 752,
    parameter int   H_TOTAL      = 800,
    parameter int   VSYNC_START  = 490,
    parameter int   VSYNC_END    = 492,
    parameter int   V_TOTAL      = 525,
    parameter int   X_POS_W      = $clog2(H_TOTAL),
    parameter int   Y_POS_W      = $clog2(V_TOTAL),
    parameter logic HSYNC_POL    = 1'b0,
    parameter logic VSYNC_POL    = 1'b0,
    parameter int   PIPE_DELAY   = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    output logic [X_POS_W-1:0] x_o,
    output logic [Y_POS_W-1:0] y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam logic [X_POS_W-1:0] H_LAST  = X_POS_W'(H_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] V_LAST  = Y_POS_W'(V_TOTAL - 1);
    localparam logic [X_POS_W-1:0] H_RES_C = X_POS_W'(SCREEN_H_RES);
    localparam logic [Y_POS_W-1:0] V_RES_C = Y_POS_W'(SCREEN_V_RES);
    localparam logic [X_POS_W-1:0] HS_C    = X_POS_W'(HSYNC_START);
    localparam logic [X_POS_W-1:0] HE_C    = X_POS_W'(HSYNC_END);
    localparam logic [Y_POS_W-1:0] VS_C    = Y_POS_W'(VSYNC_START);
    localparam logic [Y_POS_W-1:0] VE_C    = Y_POS_W'(VSYNC_END);

    // Stage layout: {hsync, vsync, de, line_start, frame_start}, syncs at output level.
    localparam logic [4:0] STAGE_IDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000};

    logic [X_POS_W-1:0] r_h;
    logic [Y_POS_W-1:0] r_v;
    logic [4:0]         r_pipe [PIPE_DELAY];

    logic w_de;
    logic w_hs_act;
    logic w_vs_act;
    logic w_line_start;
    logic w_frame_start;
    logic [4:0] w_stage_in;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_h <= '0;
            r_v <= '0;
        end else if (en_i) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + Y_POS_W'(1);
            end else begin
                r_h <= r_h + X_POS_W'(1);
            end
        end
    end

    assign w_de          = (r_h < H_RES_C) && (r_v < V_RES_C);
    assign w_hs_act      = (r_h >= HS_C) && (r_h < HE_C);
    assign w_vs_act      = (r_v >= VS_C) && (r_v < VE_C);
    assign w_line_start  = (r_h == '0);
    assign w_frame_start = (r_h == '0) && (r_v == '0);
    assign w_stage_in    = {w_hs_act ? HSYNC_POL : ~HSYNC_POL,
                            w_vs_act ? VSYNC_POL : ~VSYNC_POL,
                            w_de, w_line_start, w_frame_start};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= STAGE_IDLE;
        end else if (en_i) begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign x_o           = r_h;
    assign y_o           = r_v;
    assign hsync_o       = r_pipe[PIPE_DELAY-1][4];
    assign vsync_o       = r_pipe[PIPE_DELAY-1][3];
    assign de_o          = r_pipe[PIPE_DELAY-1][2];
    assign line_start_o  = r_pipe[PIPE_DELAY-1][1];
    assign frame_start_o = r_pipe[PIPE_DELAY-1][0];

endmodule
